// File: rtl/date_set_ctrl.sv
// date_set_ctrl: front-panel run/edit/commit sequencer for a BCD YY.MM.DD date counter.
module date_set_ctrl #(
  parameter int         BLINK_DIV = 8,
  parameter logic [7:0] YEAR_MIN  = 8'h21,
  parameter logic [7:0] YEAR_MAX  = 8'h48
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick,
  input  logic        enable,
  input  logic        btn_mode,
  input  logic        btn_inc,
  input  logic [23:0] cur_date,
  output logic        run_en,
  output logic        load,
  output logic [23:0] load_date,
  output logic [1:0]  edit_field,
  output logic [5:0]  blank
);
  typedef enum logic [2:0] {RUN, EDIT_YY, EDIT_MM, EDIT_DD, COMMIT} state_t;
  state_t      state_q, state_d;
  logic        mode_prev_q, inc_prev_q, run_en_q, phase_q, phase_d;
  logic [23:0] edit_q, edit_d, load_date_q, load_date_d;
  logic [7:0]  cnt_q, cnt_d, yy, mm, dd, md, dd_cl;
  logic        mode_p, inc_p, edit_n;
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    return v[3:0] == 4'd9 ? {v[7:4] + 4'd1, 4'd0} : {v[7:4], v[3:0] + 4'd1};
  endfunction
  function automatic logic leap(input logic [7:0] y);
    return y[4] ? (y[3:0] == 4'd2 || y[3:0] == 4'd6)
                : (y[3:0] == 4'd0 || y[3:0] == 4'd4 || y[3:0] == 4'd8);
  endfunction
  function automatic logic [7:0] maxday(input logic [7:0] m, input logic [7:0] y);
    return m == 8'h02 ? (leap(y) ? 8'h29 : 8'h28) :
           (m == 8'h04 || m == 8'h06 || m == 8'h09 || m == 8'h11) ? 8'h30 : 8'h31;
  endfunction
  assign mode_p = btn_mode & ~mode_prev_q;
  assign inc_p  = btn_inc & ~inc_prev_q & ~mode_p;
  assign yy     = edit_q[23:16];
  assign mm     = edit_q[15:8];
  assign dd     = edit_q[7:0];
  assign md     = maxday(mm, yy);
  assign dd_cl  = dd > md ? md : dd;
  always_comb begin
    state_d     = state_q;
    edit_d      = edit_q;
    load_date_d = load_date_q;
    case (state_q)
      RUN: if (mode_p) begin
        state_d = EDIT_YY;
        edit_d  = cur_date;
      end
      EDIT_YY: if (mode_p) state_d = EDIT_MM;
        else if (inc_p) edit_d[23:16] = (yy < YEAR_MIN || yy >= YEAR_MAX) ? YEAR_MIN : bcd_inc(yy);
      EDIT_MM: if (mode_p) state_d = EDIT_DD;
        else if (inc_p) edit_d[15:8] = mm >= 8'h12 ? 8'h01 : bcd_inc(mm);
      EDIT_DD: if (mode_p) begin
        state_d     = COMMIT;
        edit_d[7:0] = dd_cl;
        load_date_d = {yy, mm, dd_cl};
      end else if (inc_p) edit_d[7:0] = dd >= md ? 8'h01 : bcd_inc(dd);
      default: state_d = RUN;
    endcase
  end
  // Entering an edit state or incrementing restarts the blink with the field visible.
  assign edit_n = state_d inside {EDIT_YY, EDIT_MM, EDIT_DD};
  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (!edit_n || state_d != state_q || inc_p) begin
      cnt_d   = '0;
      phase_d = 1'b0;
    end else if (tick) begin
      cnt_d   = cnt_q == 8'(BLINK_DIV - 1) ? 8'd0 : cnt_q + 8'd1;
      phase_d = cnt_q == 8'(BLINK_DIV - 1) ? ~phase_q : phase_q;
    end
  end
  // Edge registers follow the buttons even in reset so a held button never reads as a press.
  always_ff @(posedge clk) begin
    mode_prev_q <= btn_mode;
    inc_prev_q  <= btn_inc;
    if (!reset) begin
      state_q     <= RUN;
      run_en_q    <= 1'b0;
      edit_q      <= 24'h210101;
      load_date_q <= 24'h210101;
      cnt_q       <= '0;
      phase_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      run_en_q    <= enable && state_d == RUN;
      edit_q      <= edit_d;
      load_date_q <= load_date_d;
      cnt_q       <= cnt_d;
      phase_q     <= phase_d;
    end
  end
  assign run_en     = run_en_q;
  assign load       = state_q == COMMIT;
  assign load_date  = load_date_q;
  assign edit_field = state_q == EDIT_YY ? 2'd1 : state_q == EDIT_MM ? 2'd2 : state_q == EDIT_DD ? 2'd3 : 2'd0;
  assign blank      = !phase_q ? 6'b0 : state_q == EDIT_YY ? 6'b110000 :
                      state_q == EDIT_MM ? 6'b001100 : state_q == EDIT_DD ? 6'b000011 : 6'b0;
endmodule

// File: tb/tb_date_set_ctrl.sv
// tb_date_set_ctrl: randomized and directed checks of date_set_ctrl against a decimal date model.
module tb_date_set_ctrl;
  localparam int BD = 2;
  logic        clk = 0, reset = 0, tick = 0, enable = 0, btn_mode = 0, btn_inc = 0;
  logic [23:0] cur_date = 24'h0;
  logic        run_en, load;
  logic [23:0] load_date;
  logic [1:0]  edit_field;
  logic [5:0]  blank;
  int errors = 0, checks = 0;
  int m_mode, ey, em, ed, ly, lm, lday, m_cnt, m_ph;
  bit m_run, pm, pi, m_valid = 0;

  date_set_ctrl #(.BLINK_DIV(BD)) dut (
    .clk(clk), .reset(reset), .tick(tick), .enable(enable), .btn_mode(btn_mode),
    .btn_inc(btn_inc), .cur_date(cur_date), .run_en(run_en), .load(load),
    .load_date(load_date), .edit_field(edit_field), .blank(blank)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [23:0] got, input logic [23:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction
  function automatic int fb(input logic [7:0] b);
    return int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction
  function automatic int maxd(input int m, input int y);
    return m == 2 ? (y % 4 == 0 ? 29 : 28) : (m == 4 || m == 6 || m == 9 || m == 11) ? 30 : 31;
  endfunction

  always @(posedge clk) begin : model
    bit mp, ip;
    int nm;
    if (!reset) begin
      m_valid = 1; m_mode = 0; m_run = 0; ly = 21; lm = 1; lday = 1; m_cnt = 0; m_ph = 0;
    end else begin
      mp = btn_mode && !pm;
      ip = btn_inc && !pi && !mp;
      nm = m_mode == 4 ? 0 : mp ? m_mode + 1 : m_mode;
      if (m_mode == 0 && mp) begin
        ey = fb(cur_date[23:16]); em = fb(cur_date[15:8]); ed = fb(cur_date[7:0]);
      end
      if (ip && m_mode == 1) ey = (ey < 21 || ey >= 48) ? 21 : ey + 1;
      if (ip && m_mode == 2) em = em >= 12 ? 1 : em + 1;
      if (ip && m_mode == 3) ed = ed >= maxd(em, ey) ? 1 : ed + 1;
      if (m_mode == 3 && mp) begin
        if (ed > maxd(em, ey)) ed = maxd(em, ey);
        ly = ey; lm = em; lday = ed;
      end
      if (nm < 1 || nm > 3 || nm != m_mode || ip) begin
        m_cnt = 0; m_ph = 0;
      end else if (tick) begin
        if (m_cnt == BD - 1) begin m_cnt = 0; m_ph = 1 - m_ph; end
        else m_cnt++;
      end
      m_run = enable && nm == 0;
      m_mode = nm;
    end
    pm = btn_mode;
    pi = btn_inc;
  end

  always @(negedge clk) if (m_valid) begin
    chk("run_en", 24'(run_en), 24'(m_run));
    chk("load", 24'(load), 24'(m_mode == 4));
    chk("load_date", load_date, {to_bcd(ly), to_bcd(lm), to_bcd(lday)});
    chk("edit_field", 24'(edit_field), (m_mode >= 1 && m_mode <= 3) ? 24'(m_mode) : 24'd0);
    chk("blank", 24'(blank), (m_ph != 0 && m_mode >= 1 && m_mode <= 3) ? 24'(3 << (2 * (3 - m_mode))) : 24'd0);
  end

  task automatic tk();
    @(negedge clk);
    #1;
  endtask
  task automatic press_mode();
    btn_mode = 1; tk(); btn_mode = 0; tk();
  endtask
  task automatic press_inc();
    btn_inc = 1; tk(); btn_inc = 0; tk();
  endtask
  task automatic tick1();
    tick = 1; tk(); tick = 0; tk();
  endtask
  task automatic enter(input logic [23:0] d);
    cur_date = d; press_mode(); cur_date = 24'h991299;
  endtask
  task automatic commit_check(input string name, input logic [23:0] exp);
    btn_mode = 1; tk();
    chk({name, "_load"}, 24'(load), 24'd1);
    chk({name, "_date"}, load_date, exp);
    btn_mode = 0; tk();
    chk({name, "_done"}, 24'(load), 24'd0);
    chk({name, "_run"}, 24'(edit_field), 24'd0);
  endtask

  initial begin
    reset = 0; btn_mode = 1; btn_inc = 1; tk();
    btn_mode = 0; btn_inc = 0; tk();
    chk("rst_run_en", 24'(run_en), 24'd0);
    chk("rst_load", 24'(load), 24'd0);
    chk("rst_load_date", load_date, 24'h210101);
    chk("rst_edit_field", 24'(edit_field), 24'd0);
    chk("rst_blank", 24'(blank), 24'd0);
    reset = 1; tk();
    enable = 1; tk();
    chk("run_en_latency", 24'(run_en), 24'd1);

    enter(24'h230131);
    chk("full_field", 24'(edit_field), 24'd1);
    chk("full_run_en", 24'(run_en), 24'd0);
    press_inc(); press_mode(); press_inc(); press_mode();
    commit_check("full", 24'h240229);

    enter(24'h480315); press_inc(); press_mode(); press_mode();
    commit_check("yr_wrap", 24'h210315);
    enter(24'h251215); press_mode(); press_inc(); press_mode();
    commit_check("mo_wrap", 24'h250115);
    enter(24'h230228); press_mode(); press_mode(); press_inc();
    commit_check("feb_wrap", 24'h230201);
    enter(24'h300430); press_mode(); press_mode(); press_inc();
    commit_check("apr_wrap", 24'h300401);

    enter(24'h250510); press_mode();
    btn_mode = 1; btn_inc = 1; tk();
    chk("simul_field", 24'(edit_field), 24'd3);
    btn_mode = 0; btn_inc = 0; tk();
    commit_check("simul", 24'h250510);

    enter(24'h250510); press_mode();
    chk("blink0", 24'(blank), 24'd0);
    tick1(); chk("blink1", 24'(blank), 24'd0);
    tick1(); chk("blink2", 24'(blank), 24'b001100);
    tick1(); chk("blink3", 24'(blank), 24'b001100);
    tick1(); chk("blink4", 24'(blank), 24'd0);
    tick1(); tick1(); chk("blink6", 24'(blank), 24'b001100);
    btn_inc = 1; tk();
    chk("blink_inc", 24'(blank), 24'd0);
    btn_inc = 0; tk(); press_mode();
    commit_check("blink", 24'h250610);

    enter(24'h330715); press_inc(); press_mode(); press_inc(); press_mode(); press_inc();
    btn_mode = 1; reset = 0; tk(); tk();
    reset = 1; tk();
    chk("rst_edit_load", 24'(load), 24'd0);
    chk("rst_edit_field", 24'(edit_field), 24'd0);
    chk("rst_edit_date", load_date, 24'h210101);
    tk(); tk();
    chk("held_no_press", 24'(edit_field), 24'd0);
    btn_mode = 0; tk(); press_mode();
    chk("press_after_release", 24'(edit_field), 24'd1);
    press_mode(); press_mode(); press_mode();

    for (int i = 0; i < 4000; i++) begin
      if ($urandom % 6 == 0) btn_mode = ~btn_mode;
      if ($urandom % 3 == 0) btn_inc = ~btn_inc;
      if ($urandom % 8 == 0) enable = ~enable;
      tick = $urandom % 3 == 0;
      reset = $urandom % 400 != 0;
      cur_date = {to_bcd($urandom % 100), to_bcd(1 + $urandom % 12), to_bcd(1 + $urandom % 31)};
      tk();
    end
    reset = 1; btn_mode = 0; btn_inc = 0; tick = 0; tk(); tk();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
